fb_arbiter: RTL and testbench
=============================

# fb_arbiter

Single-port frame-buffer arbiter between the VGA scan-out path and a pixel-drawing writer. Display reads have absolute priority and a fixed read latency. Writer pixels go into a small posted-write FIFO and drain into the memory port on every cycle the display does not claim it. The block sits between the display controller, the drawing engine and the frame-buffer RAM, all in the 100 MHz `clk` domain.

## Interface
- `AW`, 17: frame-buffer address width (320x240 = 76800 words).
- `DW`, 9: pixel width, packed {red[2:0], green[2:0], blue[2:0]}.
- `FIFO_DEPTH`, 4: posted-write FIFO entries; power of two, 2..16.
- `clk`  in  1  master clock, 100 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `disp_rd`  in  1  display read request, one word per asserted cycle.
- `disp_addr`  in  AW  read address, sampled with `disp_rd`.
- `disp_valid`  out  1  `disp_data` is valid this cycle.
- `disp_data`  out  DW  read pixel.
- `wr_valid`  in  1  writer offers a pixel.
- `wr_ready`  out  1  FIFO can accept a pixel.
- `wr_addr`  in  AW  write address.
- `wr_data`  in  DW  write pixel.
- `mem_en`  out  1  memory access this cycle (registered).
- `mem_we`  out  1  1 = write, 0 = read (registered).
- `mem_addr`  out  AW  memory address (registered).
- `mem_wdata`  out  DW  write data (registered).
- `mem_rdata`  in  DW  read data, valid the cycle after a read `mem_en`.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Write push:** a transfer occurs when `wr_valid && wr_ready`. `wr_ready = (level != FIFO_DEPTH)`, derived from the registered count. There is no combinational path from `wr_valid`.
- **Arbiter states:** `ST_IDLE`, `ST_READ` and `ST_WRITE` describe the memory-port cycle. Next state is evaluated every edge, in priority order:
  - `disp_rd = 1`: go to `ST_READ`; load `mem_addr = disp_addr`, `mem_we = 0`.
  - else FIFO non-empty: go to `ST_WRITE`; pop the head; load `mem_addr`/`mem_wdata` from the head entry, `mem_we = 1`.
  - else go to `ST_IDLE`; `mem_en = 0`.
- **Memory strobe:** `mem_en = 1` in `ST_READ` and `ST_WRITE`.
- **Read return:** a one-bit delay line tracks `ST_READ`. The cycle after `ST_READ`, `mem_rdata` is registered into `disp_data` and `disp_valid` is pulsed.
- **Back-to-back reads:** fully pipelined, one result per cycle.
- **FIFO full with simultaneous pop:** `wr_ready` stays low for that cycle. It rises the following cycle.
- **Empty FIFO with simultaneous push:** the new entry cannot be popped in the same cycle. It is first eligible next cycle.
- **Push and pop in the same cycle:** `fifo_level` is unchanged.
- **Read/write hazard:** there is no forwarding. A read to an address with a pending FIFO write returns the old memory contents. Tearing is accepted.
- **Writer starvation:** the writer is starved while `disp_rd` is held. The display controller leaves blanking intervals for draining, so no starvation counter is needed.
- **Reset:** asynchronous; takes effect mid-operation.
  - FIFO is emptied; an in-flight read is discarded.
  - State returns to `ST_IDLE`.
  - Outputs: `mem_en = 0`, `mem_we = 0`, `mem_addr = 0`, `mem_wdata = 0`, `disp_valid = 0`, `disp_data = 0`, `fifo_level = 0`, `wr_ready = 1` (the first cycle after reset releases).

## Timing
- **Read latency:** `disp_rd` sampled at edge N gives `mem_en` high in cycle N+1, `mem_rdata` in cycle N+2, and `disp_valid`/`disp_data` in cycle N+3. The latency is a fixed 3 cycles, independent of FIFO state.
- **Write latency:** a pixel pushed at edge N with no display traffic appears on the memory port in cycle N+2 at the earliest.
- **Throughput:** exactly one memory access per cycle maximum.

## Structure
- **Package `fb_pkg`:** holds `AW`/`DW` defaults, the `arb_state_t` enum (`ST_IDLE`/`ST_READ`/`ST_WRITE`), and the packed FIFO entry type `{addr, data}`.
- **Sub-module `wr_fifo`:** synchronous FIFO with:
  - `push`, `pop`, `din`, `dout`, `full`, `empty`, `level`;
  - registered count;
  - pointer wrap modulo `FIFO_DEPTH`.
- **Top `fb_arbiter`:** instantiates `wr_fifo` and holds the arbiter FSM, the memory-port registers and the read-return pipe.

## Test plan
- **Reset values:** assert `rst` mid-stream with 3 FIFO entries and a read in flight. Required: all outputs take the reset values immediately, no `disp_valid` follows, and `fifo_level = 0`.
- **Read pipelining:** `disp_rd` for 4 consecutive cycles at addresses 0..3, memory model preloaded with 0x1A0+addr. Required: `disp_valid` for 4 consecutive cycles starting 3 cycles after the first request, data 0x1A0..0x1A3 in order.
- **Write drain:** push (addr 0x00010, 0x1FF) with `disp_rd = 0`. Required: `mem_en = 1`, `mem_we = 1`, `mem_addr = 0x10`, `mem_wdata = 0x1FF` exactly 2 cycles later; `fifo_level` returns to 0.
- **FIFO full:** push 5 pixels while `disp_rd` is held high. Required: `wr_ready` falls after the 4th push, `fifo_level = 4`, and no `ST_WRITE` cycle occurs. Release `disp_rd`: 4 writes issue on consecutive cycles in push order.
- **Push/pop at full:** FIFO at 3 entries, push and pop in the same cycle. Required: `fifo_level` stays 3 and `wr_ready` stays high.
- **Read/write hazard:** write 0x055 to address 7, then read address 7 while the write is still queued. Required: the read returns the old value. A read issued after the write drains returns 0x055.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and defaults for the frame-buffer arbiter slice.
package fb_pkg;

  localparam int FB_AW         = 17;
  localparam int FB_DW         = 9;
  localparam int FB_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } arb_state_t;

  // Posted-write entry: address in the upper bits, pixel in the lower bits.
  typedef struct packed {
    logic [FB_AW-1:0] addr;
    logic [FB_DW-1:0] data;
  } fb_entry_t;

endpackage

// File: rtl/fb_arbiter_wr_fifo.sv
// Small posted-write FIFO with a registered occupancy count.
// Pointers wrap naturally because the depth is a power of two.
module wr_fifo
  import fb_pkg::*;
#(
  parameter int WIDTH = $bits(fb_entry_t),
  parameter int DEPTH = FB_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Advance pointers and the occupancy count for this cycle's push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset; the count decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer port arbiter: display reads always win the single memory
// port, queued writer pixels drain on every cycle the display leaves free.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int AW         = FB_AW,
  parameter int DW         = FB_DW,
  parameter int FIFO_DEPTH = FB_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          disp_rd,
  input  logic [AW-1:0]                 disp_addr,
  output logic                          disp_valid,
  output logic [DW-1:0]                 disp_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [DW-1:0]                 wr_data,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [AW-1:0]                 mem_addr,
  output logic [DW-1:0]                 mem_wdata,
  input  logic [DW-1:0]                 mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  arb_state_t        state_q, state_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic              rd_pipe_q, rd_pipe_d;
  logic              disp_valid_q, disp_valid_d;
  logic [DW-1:0]     disp_data_q, disp_data_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [AW+DW-1:0]  fifo_dout;
  logic [AW-1:0]     head_addr;
  logic [DW-1:0]     head_data;

  // Ready comes only from the registered count, never from wr_valid.
  assign wr_ready  = !fifo_full;
  assign fifo_push = wr_valid && !fifo_full;
  assign fifo_pop  = !disp_rd && !fifo_empty;
  assign head_addr = fifo_dout[AW+DW-1:DW];
  assign head_data = fifo_dout[DW-1:0];

  wr_fifo #(
    .WIDTH (AW + DW),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({wr_addr, wr_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Pick next memory cycle: display read first, then FIFO head, else idle.
  always_comb begin
    state_d     = ST_IDLE;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (disp_rd) begin
      state_d    = ST_READ;
      mem_addr_d = disp_addr;
    end else if (!fifo_empty) begin
      state_d     = ST_WRITE;
      mem_addr_d  = head_addr;
      mem_wdata_d = head_data;
    end
  end

  // Read return: one delay stage to meet the RAM, then capture its data.
  always_comb begin
    rd_pipe_d    = (state_q == ST_READ);
    disp_valid_d = rd_pipe_q;
    disp_data_d  = rd_pipe_q ? mem_rdata : disp_data_q;
  end

  // Arbiter state, memory-port and read-return registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_pipe_q    <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_pipe_q    <= rd_pipe_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
    end
  end

  assign mem_en     = (state_q != ST_IDLE);
  assign mem_we     = (state_q == ST_WRITE);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboard bench for fb_arbiter with a behavioural frame-buffer RAM.
module tb_fb_arbiter;

  localparam int AW = 17;
  localparam int DW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_rd;
  logic [AW-1:0] disp_addr;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [2:0]    fifo_level;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            due;
  } wr_exp_t;

  rd_exp_t rq[$];
  wr_exp_t wq[$];

  int cyc     = 0;
  int n_cmp   = 0;
  int n_bad   = 0;
  int rd_seen = 0;
  int wr_seen = 0;

  logic [DW-1:0] mem_aa [int];

  fb_arbiter #(
    .AW         (AW),
    .DW         (DW),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .disp_rd    (disp_rd),
    .disp_addr  (disp_addr),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .fifo_level (fifo_level)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Cycle counter: holds the index of the edge that opened the current cycle
  always @(posedge clk) cyc <= cyc + 1;

  // Initial RAM contents for any address not yet written
  function automatic logic [DW-1:0] preload(input int a);
    if (a < 4) return DW'(32'h1A0 + a);
    if (a == 7) return 9'h0F0;
    return DW'(a * 5 + 17);
  endfunction

  // Single-port RAM with one cycle of read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_aa[int'(mem_addr)] = mem_wdata;
      else mem_rdata <= mem_aa.exists(int'(mem_addr)) ? mem_aa[int'(mem_addr)]
                                                      : preload(int'(mem_addr));
    end
  end

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: pop scoreboard entries as reads return and writes hit the RAM
  always @(negedge clk) begin : monitor
    rd_exp_t re;
    wr_exp_t we;
    if (!rst) begin
      if (disp_valid) begin
        rd_seen++;
        if (rq.size() == 0) checkOutput("rdUnexpected", 32'd1, 32'd0);
        else begin
          re = rq.pop_front();
          checkOutput("rdData", 32'(disp_data), 32'(re.data));
          checkOutput("rdLatency", 32'(cyc), 32'(re.due));
        end
      end
      if (mem_en && mem_we) begin
        wr_seen++;
        if (wq.size() == 0) checkOutput("wrUnexpected", 32'd1, 32'd0);
        else begin
          we = wq.pop_front();
          checkOutput("wrAddr", 32'(mem_addr), 32'(we.addr));
          checkOutput("wrData", 32'(mem_wdata), 32'(we.data));
          if (we.due >= 0) checkOutput("wrLatency", 32'(cyc), 32'(we.due));
        end
      end
    end
  end

  // Drive one cycle of inputs and record what the DUT owes in return
  task automatic applyStimulus(input logic rd, input logic [AW-1:0] raddr, input logic [DW-1:0] rexp,
                               input logic wv, input logic [AW-1:0] waddr, input logic [DW-1:0] wdat,
                               input int wdue);
    rd_exp_t r;
    wr_exp_t w;
    disp_rd   = rd;
    disp_addr = raddr;
    wr_valid  = wv;
    wr_addr   = waddr;
    wr_data   = wdat;
    if (rd) begin
      r.data = rexp;
      r.due  = cyc + 3;
      rq.push_back(r);
    end
    if (wv && wr_ready) begin
      w.addr = waddr;
      w.data = wdat;
      w.due  = (wdue < 0) ? -1 : cyc + wdue;
      wq.push_back(w);
    end
    @(posedge clk);
    #1;
    disp_rd  = 1'b0;
    wr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, -1);
  endtask

  // Idle until every queued write and read has been observed, bounded
  task automatic waitDrain();
    for (int i = 0; i < 40 && (fifo_level != 0 || wq.size() != 0 || rq.size() != 0); i++) idle(1);
    checkOutput("drainLevel", 32'(fifo_level), 32'd0);
    checkOutput("drainWrQueue", 32'(wq.size()), 32'd0);
    checkOutput("drainRdQueue", 32'(rq.size()), 32'd0);
  endtask

  // Hard stop if something hangs
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base_rd;
    int base_wr;
    int r;
    rst       = 1'b1;
    disp_rd   = 1'b0;
    disp_addr = '0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    #3;
    checkOutput("rstMemEn", 32'(mem_en), 32'd0);
    checkOutput("rstMemWe", 32'(mem_we), 32'd0);
    checkOutput("rstDispValid", 32'(disp_valid), 32'd0);
    checkOutput("rstLevel", 32'(fifo_level), 32'd0);
    checkOutput("rstWrReady", 32'(wr_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    $display("[TB] read pipelining");
    base_rd = rd_seen;
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, AW'(i), DW'(32'h1A0 + i), 1'b0, '0, '0, -1);
    idle(5);
    checkOutput("pipeCount", 32'(rd_seen - base_rd), 32'd4);

    $display("[TB] write drain");
    applyStimulus(1'b0, '0, '0, 1'b1, 17'h00010, 9'h1FF, 2);
    waitDrain();

    $display("[TB] fifo full under display traffic");
    base_wr = wr_seen;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        checkOutput("fullReady", 32'(wr_ready), 32'd0);
        checkOutput("fullLevel", 32'(fifo_level), 32'd4);
      end else begin
        checkOutput("fillReady", 32'(wr_ready), 32'd1);
      end
      applyStimulus(1'b1, AW'(32'h1000 + i), preload(32'h1000 + i),
                    1'b1, AW'(32'h20 + i), DW'(32'h100 + i), -1);
    end
    checkOutput("fullLevelHeld", 32'(fifo_level), 32'd4);
    checkOutput("fullQueued", 32'(wq.size()), 32'd4);
    checkOutput("noWriteWhileRd", 32'(wr_seen - base_wr), 32'd0);
    r = cyc;
    for (int j = 0; j < wq.size(); j++) wq[j].due = r + 1 + j;
    waitDrain();
    checkOutput("fullWrites", 32'(wr_seen - base_wr), 32'd4);

    $display("[TB] push and pop together");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, AW'(32'h1100 + i), preload(32'h1100 + i),
                    1'b1, AW'(32'h30 + i), DW'(32'h0A0 + i), -1);
    checkOutput("ppLevelBefore", 32'(fifo_level), 32'd3);
    applyStimulus(1'b0, '0, '0, 1'b1, 17'h00033, 9'h0A3, -1);
    checkOutput("ppLevel", 32'(fifo_level), 32'd3);
    checkOutput("ppReady", 32'(wr_ready), 32'd1);
    waitDrain();

    $display("[TB] read/write hazard");
    applyStimulus(1'b0, '0, '0, 1'b1, 17'd7, 9'h055, -1);
    applyStimulus(1'b1, 17'd7, 9'h0F0, 1'b0, '0, '0, -1);
    waitDrain();
    applyStimulus(1'b1, 17'd7, 9'h055, 1'b0, '0, '0, -1);
    waitDrain();

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, AW'(32'h1200 + i), preload(32'h1200 + i),
                    1'b1, AW'(32'h40 + i), DW'(32'h0C0 + i), -1);
    checkOutput("preRstLevel", 32'(fifo_level), 32'd3);
    checkOutput("preRstMemEn", 32'(mem_en), 32'd1);
    disp_rd   = 1'b1;
    disp_addr = 17'h01203;
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midRstMemEn", 32'(mem_en), 32'd0);
    checkOutput("midRstMemWe", 32'(mem_we), 32'd0);
    checkOutput("midRstMemAddr", 32'(mem_addr), 32'd0);
    checkOutput("midRstMemWdata", 32'(mem_wdata), 32'd0);
    checkOutput("midRstDispValid", 32'(disp_valid), 32'd0);
    checkOutput("midRstDispData", 32'(disp_data), 32'd0);
    checkOutput("midRstLevel", 32'(fifo_level), 32'd0);
    checkOutput("midRstWrReady", 32'(wr_ready), 32'd1);
    rq.delete();
    wq.delete();
    disp_rd = 1'b0;
    base_rd = rd_seen;
    base_wr = wr_seen;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(6);
    checkOutput("postRstNoValid", 32'(rd_seen - base_rd), 32'd0);
    checkOutput("postRstNoWrite", 32'(wr_seen - base_wr), 32'd0);
    checkOutput("postRstLevel", 32'(fifo_level), 32'd0);
    checkOutput("postRstWrReady", 32'(wr_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
